// File: rtl/sc_config_sync.sv
`default_nettype none
// ============================================================================
//  Module   : sc_config_sync
//  Purpose  : Frame-synchronous shadow/active configuration controller for
//             the scanconverter output pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module sc_config_sync #(
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic        PCLK_OUT_i,
  input  logic        reset_n,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  input  logic        commit_req_i,
  input  logic        force_i,
  input  logic        vsync_i,
  output logic [31:0] hv_out_config_o,
  output logic [31:0] hv_out_config2_o,
  output logic [31:0] hv_out_config3_o,
  output logic [31:0] xy_out_config_o,
  output logic [31:0] xy_out_config2_o,
  output logic [31:0] misc_config_o,
  output logic [31:0] sl_config_o,
  output logic [31:0] sl_config2_o,
  output logic        testpattern_enable_o,
  output logic        commit_pending_o,
  output logic        commit_done_o,
  output logic        timeout_o,
  output logic [7:0]  frame_cnt_o
);

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [31:0]          r_shadow [0:7];
  logic [31:0]          r_active [0:7];
  logic                 r_tp_shadow;
  logic                 r_tp_active;
  logic                 r_vsync_prev;
  logic                 r_force_q;
  logic                 r_done;
  logic                 r_timeout;
  logic [7:0]           r_frame_cnt;
  logic [31:0]          r_rd_data;

  logic                 w_vs_fall;
  logic                 w_req_norm;
  logic                 w_req_force;
  logic                 w_cnt_last;
  logic                 w_commit;
  logic [31:0]          w_rd_mux;

  assign w_vs_fall   = r_vsync_prev & ~vsync_i;
  assign w_req_norm  = commit_req_i & ~force_i;
  assign w_req_force = commit_req_i & force_i;
  assign w_cnt_last  = (r_cnt == c_CNT_LAST);

  // A forced request is registered and applied one edge later; it also
  // overrides a vs_fall or timeout coinciding with it while armed.
  assign w_commit = r_force_q |
                    ((r_state == ST_ARMED) & ~w_req_force & (w_vs_fall | w_cnt_last));

  always_ff @(posedge PCLK_OUT_i or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_shadow[i] <= '0;
      r_tp_shadow <= 1'b0;
    end else if (wr_en_i) begin
      if (!wr_addr_i[3]) begin
        r_shadow[wr_addr_i[2:0]] <= wr_data_i;
      end else if (wr_addr_i == 4'd8) begin
        r_tp_shadow <= wr_data_i[0];
      end
    end
  end

  always_ff @(posedge PCLK_OUT_i or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_active[i] <= '0;
      r_tp_active <= 1'b0;
    end else if (w_commit) begin
      for (int i = 0; i < 8; i++) r_active[i] <= r_shadow[i];
      r_tp_active <= r_tp_shadow;
    end
  end

  always_ff @(posedge PCLK_OUT_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_vsync_prev <= 1'b1;
      r_force_q    <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_vsync_prev <= vsync_i;
      r_force_q    <= w_req_force;
      r_done       <= w_commit;
      if (w_vs_fall) r_frame_cnt <= r_frame_cnt + 8'd1;

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_req_norm) begin
            r_state   <= ST_ARMED;
            r_timeout <= 1'b0;
          end else if (w_req_force) begin
            r_timeout <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (w_req_force || w_vs_fall) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_cnt_last) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (!rd_addr_i[3]) begin
      w_rd_mux = r_shadow[rd_addr_i[2:0]];
    end else if (rd_addr_i == 4'd8) begin
      w_rd_mux = {31'b0, r_tp_shadow};
    end else if (rd_addr_i == 4'd9) begin
      w_rd_mux = {21'b0, r_frame_cnt, 1'b0, r_timeout, (r_state == ST_ARMED)};
    end
  end

  always_ff @(posedge PCLK_OUT_i or negedge reset_n) begin
    if (!reset_n) r_rd_data <= '0;
    else          r_rd_data <= w_rd_mux;
  end

  assign rd_data_o            = r_rd_data;
  assign hv_out_config_o      = r_active[0];
  assign hv_out_config2_o     = r_active[1];
  assign hv_out_config3_o     = r_active[2];
  assign xy_out_config_o      = r_active[3];
  assign xy_out_config2_o     = r_active[4];
  assign misc_config_o        = r_active[5];
  assign sl_config_o          = r_active[6];
  assign sl_config2_o         = r_active[7];
  assign testpattern_enable_o = r_tp_active;
  assign commit_pending_o     = (r_state == ST_ARMED);
  assign commit_done_o        = r_done;
  assign timeout_o            = r_timeout;
  assign frame_cnt_o          = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sc_config_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sc_config_sync
//  Purpose  : Directed self-checking bench for sc_config_sync.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sc_config_sync;

  localparam int c_TO = 100;

  logic        PCLK_OUT_i = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [3:0]  wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic [3:0]  rd_addr_i = '0;
  logic        commit_req_i = 1'b0;
  logic        force_i = 1'b0;
  logic        vsync_i = 1'b1;
  logic [31:0] rd_data_o;
  logic [31:0] act [0:7];
  logic        testpattern_enable_o, commit_pending_o, commit_done_o, timeout_o;
  logic [7:0]  frame_cnt_o;

  sc_config_sync #(.TIMEOUT_CYCLES(c_TO)) u_dut (
    .PCLK_OUT_i           (PCLK_OUT_i),
    .reset_n              (reset_n),
    .wr_en_i              (wr_en_i),
    .wr_addr_i            (wr_addr_i),
    .wr_data_i            (wr_data_i),
    .rd_addr_i            (rd_addr_i),
    .rd_data_o            (rd_data_o),
    .commit_req_i         (commit_req_i),
    .force_i              (force_i),
    .vsync_i              (vsync_i),
    .hv_out_config_o      (act[0]),
    .hv_out_config2_o     (act[1]),
    .hv_out_config3_o     (act[2]),
    .xy_out_config_o      (act[3]),
    .xy_out_config2_o     (act[4]),
    .misc_config_o        (act[5]),
    .sl_config_o          (act[6]),
    .sl_config2_o         (act[7]),
    .testpattern_enable_o (testpattern_enable_o),
    .commit_pending_o     (commit_pending_o),
    .commit_done_o        (commit_done_o),
    .timeout_o            (timeout_o),
    .frame_cnt_o          (frame_cnt_o)
  );

  always #5 PCLK_OUT_i = ~PCLK_OUT_i;

  typedef struct packed {
    logic             tp;
    logic [7:0][31:0] w;
  } snap_t;

  snap_t       cq[$];
  logic [31:0] rq[$];
  logic [31:0] m_sh [0:7];
  logic        m_tp;
  int          m_frames;
  logic        m_vs_prev;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: the frame model sees the same vsync value the DUT samples.
  task automatic tick();
    if (!reset_n) m_vs_prev = 1'b1;
    else begin
      if (m_vs_prev && !vsync_i) m_frames++;
      m_vs_prev = vsync_i;
    end
    @(posedge PCLK_OUT_i);
    #1;
  endtask

  function automatic snap_t snap();
    snap_t s;
    for (int i = 0; i < 8; i++) s.w[i] = m_sh[i];
    s.tp = m_tp;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_sh[i] = '0;
    m_tp = 1'b0;
    m_frames = 0;
    m_vs_prev = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
    if (a < 4'd8) m_sh[a[2:0]] = d;
    else if (a == 4'd8) m_tp = d[0];
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    rd_addr_i = a;
    rq.push_back(exp);
    tick();
    chk($sformatf("rd_a%0d", a), rd_data_o, rq.pop_front());
  endtask

  task automatic check_commit(input string tag);
    snap_t s;
    if (cq.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    s = cq.pop_front();
    for (int i = 0; i < 8; i++) chk($sformatf("%s_w%0d", tag, i), act[i], s.w[i]);
    chk({tag, "_tp"}, testpattern_enable_o, s.tp);
    chk({tag, "_done"}, commit_done_o, 1'b1);
    chk({tag, "_frame"}, frame_cnt_o, m_frames[7:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    for (int i = 0; i < 8; i++) chk($sformatf("rst_w%0d", i), act[i], 32'd0);
    chk("rst_tp", testpattern_enable_o, 1'b0);
    chk("rst_pending", commit_pending_o, 1'b0);
    chk("rst_done", commit_done_o, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_frame", frame_cnt_o, 8'd0);
    for (int a = 0; a < 16; a++) rd(4'(a), 32'd0);

    // Commit on VSYNC falling edge
    wr(4'd0, 32'h12345678);
    commit_req_i = 1'b1; tick(); commit_req_i = 1'b0;
    chk("arm_pending", commit_pending_o, 1'b1);
    chk("arm_hv", act[0], 32'd0);
    repeat (3) tick();
    chk("wait_pending", commit_pending_o, 1'b1);
    chk("wait_hv", act[0], 32'd0);
    cq.push_back(snap());
    vsync_i = 1'b0; tick();
    check_commit("vs_commit");
    chk("vs_pending", commit_pending_o, 1'b0);
    vsync_i = 1'b1; tick();
    chk("vs_done_once", commit_done_o, 1'b0);

    // Shadow write in the commit cycle only reaches the shadow
    wr(4'd6, 32'h55);
    commit_req_i = 1'b1; tick(); commit_req_i = 1'b0;
    cq.push_back(snap());
    vsync_i = 1'b0; wr_en_i = 1'b1; wr_addr_i = 4'd6; wr_data_i = 32'hAA;
    tick();
    wr_en_i = 1'b0; m_sh[6] = 32'hAA;
    check_commit("wr_vs");
    vsync_i = 1'b1; tick();
    // Request coinciding with vs_fall from IDLE waits for the next frame
    commit_req_i = 1'b1; vsync_i = 1'b0; tick(); commit_req_i = 1'b0;
    chk("coinc_pending", commit_pending_o, 1'b1);
    chk("coinc_done", commit_done_o, 1'b0);
    chk("coinc_sl", act[6], 32'h55);
    vsync_i = 1'b1; tick();
    cq.push_back(snap());
    vsync_i = 1'b0; tick();
    check_commit("second");
    vsync_i = 1'b1; tick();

    // Read of an address written in the same cycle returns the old value
    wr_en_i = 1'b1; wr_addr_i = 4'd1; wr_data_i = 32'h11111111; rd_addr_i = 4'd1;
    rq.push_back(m_sh[1]);
    tick();
    wr_en_i = 1'b0; m_sh[1] = 32'h11111111;
    chk("rdwr_old", rd_data_o, rq.pop_front());
    rd(4'd1, m_sh[1]);
    wr(4'd12, 32'hDEADBEEF);
    for (int a = 0; a < 8; a++) rd(4'(a), m_sh[a]);

    // Timeout fallback
    wr(4'd0, 32'hCAFE0001);
    commit_req_i = 1'b1; tick(); commit_req_i = 1'b0;
    cq.push_back(snap());
    cyc = 0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (commit_done_o) begin cyc = k; break; end
    end
    chk("to_latency", cyc, c_TO);
    check_commit("timeout");
    chk("to_flag", timeout_o, 1'b1);
    chk("to_pending", commit_pending_o, 1'b0);
    rd(4'd9, {21'b0, m_frames[7:0], 1'b0, 1'b1, 1'b0});
    commit_req_i = 1'b1; tick(); commit_req_i = 1'b0;
    chk("to_clear", timeout_o, 1'b0);
    chk("rearm_pending", commit_pending_o, 1'b1);

    // Forced request while armed, coinciding with vs_fall
    wr(4'd2, 32'h0BADF00D);
    commit_req_i = 1'b1; force_i = 1'b1; vsync_i = 1'b0; tick();
    commit_req_i = 1'b0; force_i = 1'b0; vsync_i = 1'b1;
    chk("farm_pending", commit_pending_o, 1'b0);
    chk("farm_done", commit_done_o, 1'b0);
    chk("farm_old", act[2], 32'd0);
    cq.push_back(snap());
    tick();
    check_commit("force_armed");
    chk("farm_timeout", timeout_o, 1'b0);
    tick();
    chk("farm_done_once", commit_done_o, 1'b0);

    // Forced request from IDLE enables the test pattern without VSYNC
    wr(4'd8, 32'hFFFFFFFF);
    rd(4'd8, 32'd1);
    commit_req_i = 1'b1; force_i = 1'b1; tick();
    commit_req_i = 1'b0; force_i = 1'b0;
    chk("fidle_tp_old", testpattern_enable_o, 1'b0);
    chk("fidle_pending", commit_pending_o, 1'b0);
    cq.push_back(snap());
    tick();
    check_commit("force_idle");
    chk("fidle_timeout", timeout_o, 1'b0);

    // Reset while armed
    commit_req_i = 1'b1; tick(); commit_req_i = 1'b0;
    chk("rarm_pending", commit_pending_o, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rarm_pend0", commit_pending_o, 1'b0);
    chk("rarm_hv", act[0], 32'd0);
    chk("rarm_tp", testpattern_enable_o, 1'b0);
    chk("rarm_frame", frame_cnt_o, 8'd0);
    chk("rarm_done", commit_done_o, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("rarm_no_done", commit_done_o, 1'b0);
    rd(4'd0, 32'd0);

    // Frame counter wraps
    repeat (257) begin
      vsync_i = 1'b0; tick();
      vsync_i = 1'b1; tick();
    end
    chk("frame_wrap", frame_cnt_o, 8'd1);
    chk("frame_model", frame_cnt_o, m_frames[7:0]);
    rd(4'd9, {21'b0, 8'd1, 3'b000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sc_config_sync.md
# sc_config_sync

Frame-synchronous configuration controller for the scanconverter output pipeline. Firmware writes new timing, scaling and scanline words into shadow registers at any time. A commit request arms the block, and the active configuration driving the scanconverter is replaced atomically on the next output VSYNC leading edge, so no frame is rendered with a mix of old and new settings. A timeout fallback and a force option cover the case where output timing is stopped.

## Interface
- TIMEOUT_CYCLES, 4000000: clock cycles spent armed without a VSYNC edge before the block commits anyway.
- PCLK_OUT_i  in  1  output pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en_i  in  1  shadow write strobe; one word per cycle.
- wr_addr_i  in  4  shadow word select, 0–8.
- wr_data_i  in  32  shadow write data.
- rd_addr_i  in  4  readback select.
- rd_data_o  out  32  readback data, registered.
- commit_req_i  in  1  single-cycle commit request.
- force_i  in  1  qualifies commit_req_i; commit on the next clock without waiting for VSYNC.
- vsync_i  in  1  scanconverter VSYNC_o, active low.
- hv_out_config_o, hv_out_config2_o, hv_out_config3_o, xy_out_config_o, xy_out_config2_o, misc_config_o, sl_config_o, sl_config2_o  out  32 each  active configuration.
- testpattern_enable_o  out  1  active test pattern enable.
- commit_pending_o  out  1  high while armed.
- commit_done_o  out  1  one-cycle pulse in the cycle after active registers load.
- timeout_o  out  1  sticky: the last commit was caused by timeout.
- frame_cnt_o  out  8  count of VSYNC leading edges, wraps 255→0.

## Operation
- Shadow map:
  - addr 0–7 hold, in order: hv_out_config, hv_out_config2, hv_out_config3, xy_out_config, xy_out_config2, misc_config, sl_config, sl_config2.
  - addr 8 holds testpattern_enable in bit 0; bits 31:1 are ignored.
  - Writes to addr 9–15 are ignored.
- Readback:
  - addr 0–8 return the shadow words; addr 8 reads {31'b0, tp}.
  - addr 9 returns status {21'b0, frame_cnt[7:0], 1'b0, timeout, pending}.
  - addr 10–15 return 0.
- VSYNC edge: vsync_prev is a register of vsync_i. vs_fall = vsync_prev & ~vsync_i. vsync_prev resets to 1.
- State machine:
  - IDLE: on commit_req_i & ~force_i, go to ARMED, clear the timeout counter and clear timeout_o. On commit_req_i & force_i, commit and stay in IDLE.
  - ARMED: on vs_fall, commit and go to IDLE. When the timeout counter reaches TIMEOUT_CYCLES-1, commit, set timeout_o and go to IDLE. Otherwise increment the counter.
  - ARMED with commit_req_i & ~force_i: merged, no effect; the counter is not restarted.
  - ARMED with commit_req_i & force_i: commit immediately and go to IDLE, even if vs_fall or the timeout coincides. timeout_o stays 0.
- Commit:
  - All nine active registers load from the shadow values held before that clock edge.
  - A shadow write in the same cycle lands in the shadow only and is applied at the next commit.
  - commit_done_o <= 1 for exactly one cycle.
- frame_cnt increments on every vs_fall, in every state.
- Timeout counter width is clog2(TIMEOUT_CYCLES). It is held at 0 in IDLE.

## Timing
- Reset values:
  - Shadow and active words: 0.
  - testpattern_enable_o: 0; commit_pending_o: 0; commit_done_o: 0; timeout_o: 0.
  - frame_cnt_o: 0; rd_data_o: 0.
  - State: IDLE.
- commit_req_i sampled at edge t: commit_pending_o is high from t+1.
- Commit on vs_fall:
  - vsync_i first sampled low at edge e loads the active registers at e.
  - commit_pending_o drops and commit_done_o is high in cycle e..e+1 (one cycle).
  - The latency from VSYNC falling to new config is 1 clock.
- A vs_fall sampled in the same edge as a commit_req_i issued from IDLE does not commit. The block waits for the following frame.
- A forced request at edge t loads the active registers at edge t+1.
- rd_data_o has 1-cycle latency. A write and a read of the same address in the same cycle returns the old value.
- Reset asserted mid-ARMED returns to IDLE with all values at their reset state. No commit_done_o pulse occurs.

## Test plan
- Reset, then read all addresses → active outputs 0; rd status = 0; frame_cnt_o = 0.
- Write addr0 = 0x12345678, then commit_req_i, with vsync_i still high → hv_out_config_o stays 0 and commit_pending_o = 1. Drive vsync_i low → hv_out_config_o = 0x12345678 one edge later, commit_done_o pulses once, commit_pending_o = 0.
- While ARMED, write addr6 = 0xAA in the same cycle that vs_fall is sampled → sl_config_o keeps the old shadow value. A second commit then yields 0xAA.
- TIMEOUT_CYCLES = 100, commit request with vsync_i held high → commit occurs exactly 100 cycles after ARMED is entered and timeout_o = 1. The next commit_req_i clears timeout_o.
- commit_req_i & force_i from IDLE, with addr8 = 1 → testpattern_enable_o = 1 one edge later, without any VSYNC edge. timeout_o = 0.
- Toggle vsync_i for 257 frames → frame_cnt_o = 1. Status readback at addr 9 shows frame_cnt in bits 10:3.
